mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Memory-stage load/store controller for the pipelined RISC-V core. It turns a memory instruction in M into a valid/ready request on the data-memory bus and waits for the response. While the access is outstanding it drives the `StallMem` request into pipeline control. It then returns size-aligned, sign- or zero-extended load data. It detects misaligned or illegal-size accesses without issuing a bus request, and it terminates hung accesses with a timeout error.

## Interface
- `TIMEOUT`, 255: maximum cycles spent in WAIT before the access is abandoned. Legal range 2..255.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `MemReadM` input 1: load instruction in the M stage.
- `MemWriteM` input 1: store instruction in the M stage. Never high together with `MemReadM`.
- `funct3M` input 3: access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `addrM` input 32: byte address computed by the ALU.
- `wdataM` input 32: store data, with the value in the low bits.
- `req_valid` output 1: bus request valid.
- `req_ready` input 1: bus accepts the request.
- `req_we` output 1: 1 = write.
- `req_addr` output 32: `{addrM[31:2],2'b00}`.
- `req_wdata` output 32: store data shifted into its byte lanes.
- `req_wstrb` output 4: byte enables; 0 for reads.
- `resp_valid` input 1: read data or write acknowledge.
- `resp_rdata` input 32: raw read word.
- `StallMem` output 1: holds F/D/E/M while an access is outstanding.
- `load_dataM` output 32: extended load result.
- `misalignM` output 1: misaligned or illegal access, combinational.
- `bus_errM` output 1: timeout error, asserted in DONE only.

## Operation
- States: IDLE, REQ, WAIT, DONE. Encoding is free.
- Access condition: `acc = (MemReadM|MemWriteM) & ~misalignM`.
- `misalignM` = `acc_raw` AND any of the following, where `acc_raw = MemReadM|MemWriteM`:
  - H/HU with `addrM[0]`.
  - W with `addrM[1:0]!=0`.
  - `funct3M` in {011,110,111}.
  - A store with `funct3M[2]=1`.
  - A misaligned access issues no request and no stall. Trap handling is outside this block.
- IDLE:
  - If `acc`, register the request fields, set `req_valid`, and go to REQ.
  - Otherwise remain in IDLE.
- REQ:
  - `req_valid=1`.
  - All `req_*` fields are held stable until `req_valid & req_ready` at a rising edge.
  - On that handshake, go to WAIT with the timeout counter cleared.
- WAIT:
  - `req_valid=0`.
  - On `resp_valid`, capture the extended data (loads) into `load_dataM` and go to DONE.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT-1`, go to DONE with the error flag set and `load_dataM=0`.
- DONE:
  - `StallMem=0`; the M instruction advances at this edge.
  - `bus_errM` reflects the error flag.
  - Go to IDLE unconditionally and clear the error flag.
- `StallMem = (IDLE & acc) | REQ | WAIT`. The IDLE term is combinational.
- Store lanes:
  - `req_wdata = wdataM << (8*addrM[1:0])`.
  - `wstrb`: B gives `4'b0001<<addrM[1:0]`; H gives `4'b0011<<addrM[1:0]`; W gives `4'b1111`.
- Load extraction:
  - Shift `resp_rdata` right by `8*addr[1:0]`, using the registered offset.
  - Take the low byte or half.
  - Sign-extend for B/H; zero-extend for BU/HU.
- `resp_valid` outside WAIT is ignored, including a stale response after reset.

## Timing
- Reset values:
  - State IDLE.
  - `req_valid=0`, `req_we=0`, `req_addr=0`, `req_wdata=0`, `req_wstrb=0`.
  - `load_dataM=0`, `bus_errM=0`, counter 0.
  - `StallMem` follows its combinational equation.
- Reset mid-access: the state returns to IDLE and `req_valid` drops immediately (async). A later `resp_valid` is ignored.
- Minimum access with `req_ready` high in REQ and `resp_valid` in the first WAIT cycle:
  - c0: IDLE, `StallMem=1`.
  - c1: REQ, handshake.
  - c2: WAIT, response.
  - c3: DONE, `StallMem=0` and `load_dataM` valid.
  - This is 3 stall cycles.
- Every cycle of `req_ready` low adds one cycle in REQ. Every cycle of missing `resp_valid` adds one cycle in WAIT.
- The earliest response is one cycle after the handshake. A response in the handshake cycle itself is ignored.
- Timeout: DONE is entered after exactly `TIMEOUT` WAIT cycles without `resp_valid`. If `resp_valid` arrives in that final WAIT cycle, the response wins and `bus_errM=0`.
- Back-to-back accesses: DONE→IDLE, then the next M instruction starts in IDLE the following cycle.

## Test plan
- LW at `0x100`; `req_ready=1`; `resp_rdata=0xDEADBEEF` one cycle after the handshake.
  - `req_addr=0x100`, `req_wstrb=0`, `StallMem` high for 3 cycles.
  - `load_dataM=0xDEADBEEF` in DONE.
- LB at `0x103` with rdata `0x80123456` → `load_dataM=0xFFFFFF80`. LBU at the same address → `0x00000080`. LHU at `0x102` → `0x00008012`.
- SH at `0x102` with `wdataM=0x0000ABCD`; `req_ready` low for 4 cycles.
  - `req_wdata=0xABCD0000`, `req_wstrb=4'b1100`.
  - Fields stable during the wait; `StallMem` high for 7 cycles.
- LW at `0x101` → `misalignM=1`, `req_valid` stays 0, `StallMem=0`.
- `TIMEOUT=4`, `resp_valid` never asserted → 4 WAIT cycles, then DONE with `bus_errM=1` and `load_dataM=0`. The next access completes normally with `bus_errM=0`.
- Assert `rst_n=0` during WAIT, release, then drive `resp_valid` → no state change, `load_dataM=0`, `StallMem=0` if no access is pending.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store controller: turns an M-stage load/store into a valid/ready
// bus request, stalls the pipeline while it is outstanding and returns extended load data.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] addrM,
  input  logic [31:0] wdataM,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_we,
  output logic [31:0] req_addr,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_wstrb,
  input  logic        resp_valid,
  input  logic [31:0] resp_rdata,
  output logic        StallMem,
  output logic [31:0] load_dataM,
  output logic        misalignM,
  output logic        bus_errM
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state, w_state_next;
  logic [7:0]  r_cnt, w_cnt_next;
  logic        r_err, w_err_next;
  logic        r_we;
  logic [31:0] r_addr, r_wdata, r_load, w_load_next;
  logic [3:0]  r_wstrb;
  logic [1:0]  r_off;
  logic [2:0]  r_f3;

  logic        w_acc_raw, w_illegal, w_acc, w_launch;
  logic [31:0] w_wdata_sh, w_rshift, w_load_ext;
  logic [3:0]  w_wstrb;

  assign w_acc_raw = MemReadM | MemWriteM;

  always_comb begin
    case (funct3M)
      3'b000, 3'b100: w_illegal = 1'b0;
      3'b001, 3'b101: w_illegal = addrM[0];
      3'b010:         w_illegal = (addrM[1:0] != 2'b00);
      default:        w_illegal = 1'b1;
    endcase
    // Unsigned store sizes do not exist.
    if (MemWriteM && funct3M[2]) w_illegal = 1'b1;
  end

  assign misalignM = w_acc_raw & w_illegal;
  assign w_acc     = w_acc_raw & ~w_illegal;

  assign w_wdata_sh = wdataM << {addrM[1:0], 3'b000};

  always_comb begin
    case (funct3M[1:0])
      2'b00:   w_wstrb = 4'b0001 << addrM[1:0];
      2'b01:   w_wstrb = 4'b0011 << addrM[1:0];
      default: w_wstrb = 4'b1111;
    endcase
    if (!MemWriteM) w_wstrb = 4'b0000;
  end

  // Extraction uses the offset/size captured at launch, not the live M-stage inputs.
  assign w_rshift = resp_rdata >> {r_off, 3'b000};

  always_comb begin
    case (r_f3)
      3'b000:  w_load_ext = {{24{w_rshift[7]}}, w_rshift[7:0]};
      3'b001:  w_load_ext = {{16{w_rshift[15]}}, w_rshift[15:0]};
      3'b100:  w_load_ext = {24'd0, w_rshift[7:0]};
      3'b101:  w_load_ext = {16'd0, w_rshift[15:0]};
      default: w_load_ext = w_rshift;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_err_next   = r_err;
    w_load_next  = r_load;
    w_launch     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          w_state_next = S_REQ;
          w_launch     = 1'b1;
        end
      end
      S_REQ: begin
        if (req_ready) begin
          w_state_next = S_WAIT;
          w_cnt_next   = 8'd0;
        end
      end
      S_WAIT: begin
        // A response in the last WAIT cycle still wins over the timeout.
        if (resp_valid) begin
          w_state_next = S_DONE;
          w_err_next   = 1'b0;
          if (!r_we) w_load_next = w_load_ext;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = S_DONE;
          w_err_next   = 1'b1;
          w_load_next  = 32'd0;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
        w_err_next   = 1'b0;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_err   <= 1'b0;
      r_load  <= 32'd0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_wstrb <= 4'd0;
      r_off   <= 2'd0;
      r_f3    <= 3'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_err   <= w_err_next;
      r_load  <= w_load_next;
      if (w_launch) begin
        r_we    <= MemWriteM;
        r_addr  <= {addrM[31:2], 2'b00};
        r_wdata <= w_wdata_sh;
        r_wstrb <= w_wstrb;
        r_off   <= addrM[1:0];
        r_f3    <= funct3M;
      end
    end
  end

  assign req_valid  = (r_state == S_REQ);
  assign req_we     = r_we;
  assign req_addr   = r_addr;
  assign req_wdata  = r_wdata;
  assign req_wstrb  = r_wstrb;
  assign load_dataM = r_load;
  assign bus_errM   = (r_state == S_DONE) & r_err;
  assign StallMem   = ((r_state == S_IDLE) & w_acc) | (r_state == S_REQ) | (r_state == S_WAIT);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed and randomized accesses checked
// against a transaction-level model of latency, lanes, extension and timeout.
module tb_mem_access_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemReadM, MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] addrM, wdataM;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        StallMem, misalignM, bus_errM;
  logic [31:0] load_dataM;

  int total = 0;
  int bad   = 0;

  mem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .funct3M(funct3M),
    .addrM(addrM), .wdataM(wdataM),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .StallMem(StallMem), .load_dataM(load_dataM),
    .misalignM(misalignM), .bus_errM(bus_errM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic logic model_mis(input logic rd, input logic wr, input logic [2:0] f3,
                                     input logic [31:0] addr);
    logic illegal;
    if (!(rd || wr)) return 1'b0;
    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (wr && f3 >= 3'd4);
    if (illegal) return 1'b1;
    return (addr % size_of(f3)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    logic [31:0] v, b, h;
    v = rdata >> (8 * (addr % 4));
    b = v & 32'hFF;
    h = v & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b - 32'd256 : b;
      3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return rdata;
    endcase
  endfunction

  // One load/store: ready held low for rcyc REQ cycles, response after dcyc empty WAIT cycles.
  task automatic do_access(input logic rd, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int rcyc, input int dcyc);
    int          off, exp_stall, stall, w;
    logic [31:0] exp_addr, exp_wdata, exp_load;
    logic [3:0]  exp_strb;
    logic        exp_err;
    bit          done;
    off       = addr % 4;
    exp_addr  = addr - off;
    exp_wdata = wdata << (8 * off);
    exp_strb  = rd ? 4'h0 : 4'(((32'd1 << size_of(f3)) - 1) << off);
    exp_err   = (dcyc >= TO);
    exp_stall = 1 + (rcyc + 1) + (exp_err ? TO : dcyc + 1);
    exp_load  = exp_err ? 32'd0 : model_load(f3, addr, rdata);

    @(negedge clk);
    MemReadM = rd; MemWriteM = !rd; funct3M = f3; addrM = addr; wdataM = wdata;
    stall = 0;
    done  = 0;
    for (int k = 0; k < 64 && !done; k++) begin
      if (k == 0) begin
        req_ready = 1'b0; resp_valid = 1'b0;
      end else if (k <= rcyc + 1) begin
        req_ready  = (k == rcyc + 1);
        resp_valid = 1'($urandom % 2);
        resp_rdata = $urandom;
      end else begin
        w          = k - rcyc - 2;
        req_ready  = 1'($urandom % 2);
        resp_valid = (w == dcyc);
        resp_rdata = (w == dcyc) ? rdata : $urandom;
      end
      #1;
      if (k == 0) begin
        chk("idle_buserr", 32'(bus_errM), 32'd0);
        chk("idle_reqvalid", 32'(req_valid), 32'd0);
      end else if (k <= rcyc + 1) begin
        chk("req_valid", 32'(req_valid), 32'd1);
        chk("req_addr", req_addr, exp_addr);
        chk("req_we", 32'(req_we), 32'(!rd));
        chk("req_wstrb", 32'(req_wstrb), 32'(exp_strb));
        if (!rd) chk("req_wdata", req_wdata, exp_wdata);
      end
      if (StallMem) stall++;
      else done = 1;
      if (!done) @(negedge clk);
    end
    chk("stall_cycles", 32'(stall), 32'(exp_stall));
    chk("done_reqvalid", 32'(req_valid), 32'd0);
    chk("done_buserr", 32'(bus_errM), 32'(exp_err));
    if (rd) chk("load_data", load_dataM, exp_load);
    $display("access %s f3=%0d addr=%h rcyc=%0d dcyc=%0d stall=%0d load=%h err=%0b",
             rd ? "LD" : "ST", f3, addr, rcyc, dcyc, stall, load_dataM, bus_errM);
    resp_valid = 1'b0;
  endtask

  task automatic do_misalign(input logic rd, input logic [2:0] f3, input logic [31:0] addr);
    @(negedge clk);
    MemReadM = rd; MemWriteM = !rd; funct3M = f3; addrM = addr; wdataM = $urandom;
    req_ready = 1'b1; resp_valid = 1'b0;
    #1;
    chk("mis_flag", 32'(misalignM), 32'd1);
    chk("mis_stall", 32'(StallMem), 32'd0);
    chk("mis_reqvalid", 32'(req_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("mis_reqvalid_next", 32'(req_valid), 32'd0);
    chk("mis_stall_next", 32'(StallMem), 32'd0);
    $display("misalign %s f3=%0d addr=%h flag=%0b", rd ? "LD" : "ST", f3, addr, misalignM);
    MemReadM = 1'b0; MemWriteM = 1'b0; req_ready = 1'b0;
  endtask

  initial begin
    logic        rd, mis;
    logic [2:0]  f3;
    logic [31:0] addr;

    rst_n = 1'b0;
    MemReadM = 1'b0; MemWriteM = 1'b0; funct3M = 3'd0; addrM = 32'd0; wdataM = 32'd0;
    req_ready = 1'b0; resp_valid = 1'b1; resp_rdata = 32'hCAFEF00D;
    #1;
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_req_we", 32'(req_we), 32'd0);
    chk("rst_req_addr", req_addr, 32'd0);
    chk("rst_req_wdata", req_wdata, 32'd0);
    chk("rst_req_wstrb", 32'(req_wstrb), 32'd0);
    chk("rst_load", load_dataM, 32'd0);
    chk("rst_buserr", 32'(bus_errM), 32'd0);
    chk("rst_stall", 32'(StallMem), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("stale_resp_load", load_dataM, 32'd0);
    chk("stale_resp_stall", 32'(StallMem), 32'd0);
    resp_valid = 1'b0;

    do_access(1'b1, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 0, 0);
    do_access(1'b1, 3'b000, 32'h103, 32'd0, 32'h80123456, 0, 0);
    do_access(1'b1, 3'b100, 32'h103, 32'd0, 32'h80123456, 0, 0);
    do_access(1'b1, 3'b101, 32'h102, 32'd0, 32'h80123456, 1, 2);
    do_access(1'b0, 3'b001, 32'h102, 32'h0000ABCD, 32'h0, 4, 0);
    do_misalign(1'b1, 3'b010, 32'h101);
    do_access(1'b1, 3'b010, 32'h300, 32'd0, 32'h11111111, 0, 50);
    do_access(1'b1, 3'b010, 32'h304, 32'd0, 32'h22222222, 0, 1);
    do_access(1'b1, 3'b001, 32'h306, 32'd0, 32'hF00D1234, 2, TO - 1);
    do_access(1'b1, 3'b010, 32'h308, 32'd0, 32'h33333333, 0, TO);

    for (int i = 0; i < 40; i++) begin
      rd   = 1'($urandom % 2);
      f3   = 3'($urandom % 8);
      addr = $urandom;
      mis  = model_mis(rd, !rd, f3, addr);
      if (mis) do_misalign(rd, f3, addr);
      else do_access(rd, f3, addr, $urandom, $urandom, $urandom % 4, $urandom % (TO + 2));
    end

    // Reset during WAIT, then a late response that must be ignored.
    @(negedge clk);
    MemReadM = 1'b1; MemWriteM = 1'b0; funct3M = 3'b010; addrM = 32'h200;
    req_ready = 1'b0; resp_valid = 1'b0;
    @(negedge clk);
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    #1;
    chk("wait_stall", 32'(StallMem), 32'd1);
    rst_n = 1'b0; MemReadM = 1'b0;
    #1;
    chk("midrst_reqvalid", 32'(req_valid), 32'd0);
    chk("midrst_stall", 32'(StallMem), 32'd0);
    chk("midrst_load", load_dataM, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    resp_valid = 1'b1; resp_rdata = 32'h12345678;
    repeat (2) @(negedge clk);
    #1;
    chk("postrst_load", load_dataM, 32'd0);
    chk("postrst_stall", 32'(StallMem), 32'd0);
    chk("postrst_reqvalid", 32'(req_valid), 32'd0);
    chk("postrst_buserr", 32'(bus_errM), 32'd0);
    resp_valid = 1'b0;
    $display("reset-during-wait load=%h stall=%0b", load_dataM, StallMem);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
